// File: rtl/bcd_counter_mod.sv
//============================================================================
// Module   : bcd_counter_mod
// Purpose  : Loadable, bidirectional, multi-digit BCD counter with a
//            programmable modulo. Cascade stages by feeding carry_out of one
//            stage into tick of the next (e.g. sec -> min -> hour chains).
// Ports    : clk         system clock, rising edge
//            reset_n     asynchronous active-low reset
//            tick        count enable (one-clk pulse)
//            up_down     1 = count up, 0 = count down (sampled with tick)
//            load_en     synchronous load strobe (wins over tick)
//            load_value  BCD value to load, digit 0 in bits [3:0]
//            bcd_out     current count in BCD, digit 0 in bits [3:0]
//            carry_out   one-clk pulse on wrap (or on reaching the bound
//                        when saturating)
//            load_err    one-clk pulse when a load value is rejected
//            zero        combinational (bcd_out == 0)
// Config   : `define BCD_COUNTER_SATURATE_EN to saturate at 0 / MODULO-1
//            instead of wrapping.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module bcd_counter_mod #(
  parameter int NDIGITS = 2,
  parameter int MODULO  = 60
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 up_down,
  input  logic                 load_en,
  input  logic [4*NDIGITS-1:0] load_value,
  output logic [4*NDIGITS-1:0] bcd_out,
  output logic                 carry_out,
  output logic                 load_err,
  output logic                 zero
);

  localparam int W = 4 * NDIGITS;

  // Binary -> BCD conversion, used only at elaboration for the top count.
  function automatic logic [W-1:0] bin_to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] C_MAX_BCD = bin_to_bcd(MODULO - 1);

  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_err;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_load_ok;
  logic         w_at_max;
  logic         w_at_zero;

  // Ripple increment: a digit at 9 rolls to 0 and passes the carry upward.
  always_comb begin : p_inc
    logic c;
    c     = 1'b1;
    w_inc = r_count;
    for (int i = 0; i < NDIGITS; i++) begin
      if (c) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          c               = 1'b0;
        end
      end
    end
  end

  // Ripple decrement: a digit at 0 rolls to 9 and borrows from the next one.
  always_comb begin : p_dec
    logic b;
    b     = 1'b1;
    w_dec = r_count;
    for (int i = 0; i < NDIGITS; i++) begin
      if (b) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          b               = 1'b0;
        end
      end
    end
  end

  // A load is accepted only if every nibble is a decimal digit and the
  // decoded value is inside the count range.
  always_comb begin : p_load_chk
    int  bin;
    logic digits_ok;
    bin       = 0;
    digits_ok = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      if (load_value[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      bin = bin * 10 + int'(load_value[4*i +: 4]);
    end
    w_load_ok = digits_ok && (bin < MODULO);
  end

  assign w_at_max  = (r_count == C_MAX_BCD);
  assign w_at_zero = (r_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // Both flags are single-cycle pulses; default them low every edge.
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      if (load_en) begin
        if (w_load_ok) begin
          r_count <= load_value;
        end else begin
          r_count <= '0;
          r_err   <= 1'b1;
        end
      end else if (tick) begin
        if (up_down) begin
`ifdef BCD_COUNTER_SATURATE_EN
          // Hold at the top bound; pulse only on the tick that arrives there.
          if (!w_at_max) begin
            r_count <= w_inc;
            r_carry <= (w_inc == C_MAX_BCD);
          end
`else
          if (w_at_max) begin
            r_count <= '0;
            r_carry <= 1'b1;
          end else begin
            r_count <= w_inc;
          end
`endif
        end else begin
`ifdef BCD_COUNTER_SATURATE_EN
          if (!w_at_zero) begin
            r_count <= w_dec;
            r_carry <= (w_dec == '0);
          end
`else
          if (w_at_zero) begin
            r_count <= C_MAX_BCD;
            r_carry <= 1'b1;
          end else begin
            r_count <= w_dec;
          end
`endif
        end
      end
    end
  end

  assign bcd_out   = r_count;
  assign carry_out = r_carry;
  assign load_err  = r_err;
  assign zero      = w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_mod.sv
//============================================================================
// Module   : tb_bcd_counter_mod
// Purpose  : Self-checking bench for bcd_counter_mod. Three instances
//            (mod-60 x2 digits, mod-24 x2 digits, mod-1000 x3 digits) are
//            driven one at a time; a binary reference model predicts each
//            result, which is queued and compared one clock later.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_bcd_counter_mod;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        up_down = 1'b0;
  logic [11:0] load_value = '0;
  logic        tick_a = 1'b0, tick_b = 1'b0, tick_c = 1'b0;
  logic        load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;

  logic [7:0]  bcd_a, bcd_b;
  logic [11:0] bcd_c;
  logic        carry_a, carry_b, carry_c;
  logic        err_a, err_b, err_c;
  logic        zero_a, zero_b, zero_c;

  always #5 clk = ~clk;

  bcd_counter_mod #(.NDIGITS(2), .MODULO(60)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick_a), .up_down(up_down),
    .load_en(load_a), .load_value(load_value[7:0]), .bcd_out(bcd_a),
    .carry_out(carry_a), .load_err(err_a), .zero(zero_a));

  bcd_counter_mod #(.NDIGITS(2), .MODULO(24)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick_b), .up_down(up_down),
    .load_en(load_b), .load_value(load_value[7:0]), .bcd_out(bcd_b),
    .carry_out(carry_b), .load_err(err_b), .zero(zero_b));

  bcd_counter_mod #(.NDIGITS(3), .MODULO(1000)) dut_c (
    .clk(clk), .reset_n(reset_n), .tick(tick_c), .up_down(up_down),
    .load_en(load_c), .load_value(load_value), .bcd_out(bcd_c),
    .carry_out(carry_c), .load_err(err_c), .zero(zero_c));

  typedef struct {
    int          sel;
    logic [11:0] bcd;
    logic        carry;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   mstate[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic [11:0] b, output logic c,
                         output logic e, output logic z);
    case (sel)
      0:       begin b = {4'h0, bcd_a}; c = carry_a; e = err_a; z = zero_a; end
      1:       begin b = {4'h0, bcd_b}; c = carry_b; e = err_b; z = zero_b; end
      default: begin b = bcd_c;         c = carry_c; e = err_c; z = zero_c; end
    endcase
  endtask

  function automatic logic [11:0] enc(input int v, input int nd);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One clock of stimulus on a selected instance: predict, drive, then compare.
  task automatic step(input int sel, input logic ld, input logic [11:0] lv,
                      input logic tk, input logic ud, input string tag);
    int   m, nd, st, val;
    logic ok;
    exp_t e, p;
    logic [11:0] gb;
    logic gc, ge, gz;

    m  = (sel == 0) ? 60 : (sel == 1) ? 24 : 1000;
    nd = (sel == 2) ? 3 : 2;
    st = mstate[sel];
    e.sel = sel; e.carry = 1'b0; e.err = 1'b0; e.tag = tag;
    if (ld) begin
      ok  = 1'b1;
      val = 0;
      for (int i = nd - 1; i >= 0; i--) begin
        if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
        val = val * 10 + int'(lv[4*i +: 4]);
      end
      if (ok && val < m) st = val;
      else begin st = 0; e.err = 1'b1; end
    end else if (tk) begin
`ifdef BCD_COUNTER_SATURATE_EN
      if (ud && st < m - 1) begin st = st + 1; e.carry = (st == m - 1); end
      else if (!ud && st > 0) begin st = st - 1; e.carry = (st == 0); end
`else
      if (ud) begin e.carry = (st == m - 1); st = (st + 1) % m; end
      else begin e.carry = (st == 0); st = (st + m - 1) % m; end
`endif
    end
    mstate[sel] = st;
    e.bcd = enc(st, nd);
    sb.push_back(e);

    load_value = lv;
    up_down    = ud;
    load_a = (sel == 0) && ld; tick_a = (sel == 0) && tk;
    load_b = (sel == 1) && ld; tick_b = (sel == 1) && tk;
    load_c = (sel == 2) && ld; tick_c = (sel == 2) && tk;
    @(posedge clk);
    #1;
    {load_a, load_b, load_c, tick_a, tick_b, tick_c} = '0;

    p = sb.pop_front();
    get_out(p.sel, gb, gc, ge, gz);
    check({p.tag, ".bcd"},   32'(gb), 32'(p.bcd));
    check({p.tag, ".carry"}, 32'(gc), 32'(p.carry));
    check({p.tag, ".err"},   32'(ge), 32'(p.err));
    check({p.tag, ".zero"},  32'(gz), 32'(p.bcd == 12'h000));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".a_bcd"}, 32'(bcd_a), 32'h0);
    check({tag, ".a_cy"},  32'(carry_a), 32'h0);
    check({tag, ".a_err"}, 32'(err_a), 32'h0);
    check({tag, ".a_z"},   32'(zero_a), 32'h1);
    check({tag, ".b_bcd"}, 32'(bcd_b), 32'h0);
    check({tag, ".c_bcd"}, 32'(bcd_c), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] lv;
    int op;

    foreach (mstate[i]) mstate[i] = 0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // mod-60 up across the wrap
    step(0, 1, 12'h058, 0, 1, "ld58");
    step(0, 0, 12'h000, 1, 1, "up59");
    step(0, 0, 12'h000, 1, 1, "wrap00");
    step(0, 0, 12'h000, 0, 1, "hold_nocy");

    // mod-60 down with borrow and wrap
    step(0, 1, 12'h010, 0, 0, "ld10");
    step(0, 0, 12'h000, 1, 0, "dn09");
    step(0, 1, 12'h000, 0, 0, "ld00");
    step(0, 0, 12'h000, 1, 0, "dnwrap59");
    step(0, 0, 12'h000, 0, 0, "hold59");

    // mod-24 hours
    step(1, 1, 12'h023, 0, 1, "h_ld23");
    step(1, 0, 12'h000, 1, 1, "h_up00");
    step(1, 1, 12'h000, 0, 0, "h_ld00");
    step(1, 0, 12'h000, 1, 0, "h_dn23");

    // invalid loads and load-over-tick priority
    step(0, 1, 12'h025, 0, 1, "ld25");
    step(0, 1, 12'h060, 0, 1, "ld60_err");
    step(0, 1, 12'h03A, 0, 1, "ld3A_err");
    step(0, 1, 12'h059, 1, 1, "ld59_tick");
    step(0, 1, 12'h012, 1, 1, "ld12_tick");

    // direction change between ticks
    step(0, 0, 12'h000, 1, 1, "up13");
    step(0, 0, 12'h000, 1, 0, "dn12");
    step(0, 0, 12'h000, 1, 0, "dn11");

    // lower bound: wrap or saturate depending on build
    step(0, 1, 12'h001, 0, 0, "ld01");
    step(0, 0, 12'h000, 1, 0, "bnd_dn1");
    step(0, 0, 12'h000, 1, 0, "bnd_dn2");
    step(0, 0, 12'h000, 1, 0, "bnd_dn3");

    // three-digit upper bound
    step(2, 1, 12'h998, 0, 1, "k_ld998");
    step(2, 0, 12'h000, 1, 1, "k_up999");
    step(2, 0, 12'h000, 1, 1, "k_bnd_up");
    step(2, 1, 12'h099, 0, 1, "k_ld099");
    step(2, 0, 12'h000, 1, 1, "k_up100");
    step(2, 0, 12'h000, 1, 0, "k_dn099");

    // random mix on mod-60
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 4));
      lv = 12'($urandom_range(0, 255));
      case (op)
        0: step(0, 0, 12'h000, 0, 1'($urandom_range(0, 1)), "rnd_hold");
        1: step(0, 0, 12'h000, 1, 1, "rnd_up");
        2: step(0, 0, 12'h000, 1, 0, "rnd_dn");
        3: step(0, 1, lv, 0, 1, "rnd_ld");
        default: step(0, 1, lv, 1, 1'($urandom_range(0, 1)), "rnd_ldtk");
      endcase
    end

    // asynchronous reset mid-count at 37
    step(0, 1, 12'h037, 0, 1, "ld37");
    step(1, 1, 12'h015, 0, 1, "h_ld15");
    #2 reset_n = 1'b0;
    #1 check_reset("async_rst");
    foreach (mstate[i]) mstate[i] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 12'h000, 1, 1, "post_rst_up");

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
